// File: rtl/sr_ff_ctrl_pkg.sv
// Shared types and constants for the SR flip-flop command arbiter.
// FSM state encoding, S/R drive codes and the read-back counter width.
package sr_ff_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CHECK = 2'd2
  } state_t;

  // {S,R} drive codes; 2'b11 is deliberately absent.
  localparam logic [1:0] SR_HOLD = 2'b00;
  localparam logic [1:0] SR_SET  = 2'b10;
  localparam logic [1:0] SR_CLR  = 2'b01;

  localparam int CNT_W = 8;

  function automatic logic [1:0] sr_drive(input logic set_op);
    return set_op ? SR_SET : SR_CLR;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches from last_grant+1 (mod N)
// and returns a one-hot grant, its index and a valid flag.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_valid
);

  int            sum;
  logic [IW-1:0] idx;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    sum         = 0;
    idx         = '0;
    for (int i = 1; i <= N; i++) begin
      // Wrap without a modulo so non-power-of-two N stays cheap.
      sum = int'(last_grant) + i;
      if (sum >= N) sum = sum - N;
      idx = IW'(sum);
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant[idx]  = 1'b1;
        grant_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/sr_ff_arbiter.sv
// Round-robin command sequencer in front of a shared SR flip-flop.
// Define SR_FF_READBACK_EN to add the CHECK state, Q compare, timeout and err.
module sr_ff_arbiter
  import sr_ff_ctrl_pkg::*;
#(
  parameter int N       = 4,
  parameter int TIMEOUT = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic [N-1:0] op,
  input  logic         Q,
  output logic [N-1:0] ack,
  output logic         err,
  output logic         S,
  output logic         R,
  output logic         busy,
  output logic [1:0]   dbg_state
);

  localparam int IW = $clog2(N);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

  // Handshake: a requester raises req (with op stable) and holds it until it
  // sees its one-cycle ack; ack is the only completion indication.

  state_t        state_q, state_d;
  logic [IW-1:0] last_q, last_d;
  logic [N-1:0]  oh_q, oh_d;
  logic [1:0]    sr_q, sr_d;
  logic [N-1:0]  ack_q, ack_d;

  logic [N-1:0]  arb_grant;
  logic [IW-1:0] arb_idx;
  logic          arb_valid;

`ifdef SR_FF_READBACK_EN
  logic             op_q, op_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  logic unused_cfg;
  assign unused_cfg = Q ^ (^TIMEOUT_LAST);
`endif

  rr_arbiter #(
    .N  (N),
    .IW (IW)
  ) u_rr_arbiter (
    .req         (req),
    .last_grant  (last_q),
    .grant       (arb_grant),
    .grant_idx   (arb_idx),
    .grant_valid (arb_valid)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    oh_d    = oh_q;
    sr_d    = SR_HOLD;
    ack_d   = '0;
`ifdef SR_FF_READBACK_EN
    op_d    = op_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        // Skip the cycle in which ack is out: the served requester still
        // shows req there and must not be mistaken for a new request.
        if (arb_valid && (ack_q == '0)) begin
          state_d = ISSUE;
          last_d  = arb_idx;
          oh_d    = arb_grant;
          sr_d    = sr_drive(|(op & arb_grant));
`ifdef SR_FF_READBACK_EN
          op_d    = |(op & arb_grant);
`endif
        end
      end
      ISSUE: begin
`ifdef SR_FF_READBACK_EN
        state_d = CHECK;
        cnt_d   = '0;
`else
        state_d = IDLE;
        ack_d   = oh_q;
`endif
      end
`ifdef SR_FF_READBACK_EN
      CHECK: begin
        if (Q == op_q) begin
          state_d = IDLE;
          ack_d   = oh_q;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = IDLE;
          ack_d   = oh_q;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= IW'(N - 1);
      oh_q    <= '0;
      sr_q    <= SR_HOLD;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      oh_q    <= oh_d;
      sr_q    <= sr_d;
      ack_q   <= ack_d;
    end
  end

`ifdef SR_FF_READBACK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= 1'b0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      op_q  <= op_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign S         = sr_q[1];
  assign R         = sr_q[0];
  assign ack       = ack_q;
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

endmodule
